multiplier_station_scheduler: RTL

- Owns a bank of STATION_COUNT multiplier/divider reservation stations.
- Allocates a free station to each dispatched mul/div micro-op, and tracks reservations locally because station `occupied` lags `set_occupied` by one cycle.
- Round-robin arbitrates stations whose results are ready onto a single broadcast bus slot through a registered request/grant holding stage, then frees the station.

---
 rtl/multiplier_station_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multiplier_station_scheduler.sv
// Mul/div reservation-station scheduler: zero-latency dispatch allocation plus
// round-robin result capture onto a single broadcast bus slot. Optional MUL_SCHED_BYPASS_EN.
module multiplier_station_scheduler #(
    parameter int STATION_COUNT      = 4,
    parameter int SIZE               = 32,
    parameter int STATION_INDEX_SIZE = 4,
    parameter int STATION_BASE       = 0,
    parameter int LOCAL_INDEX_SIZE   = $clog2(STATION_COUNT)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                dispatch_valid,
    output logic                                dispatch_ready,
    output logic [LOCAL_INDEX_SIZE-1:0]         dispatch_station,
    output logic [STATION_COUNT-1:0]            set_occupied,
    input  logic [STATION_COUNT-1:0]            station_result_ready,
    input  logic [STATION_COUNT-1:0][SIZE-1:0]  station_result,
    output logic [STATION_COUNT-1:0]            reset_occupied,
    output logic                                bus_request,
    input  logic                                bus_grant,
    output logic [STATION_INDEX_SIZE-1:0]       bus_source,
    output logic [SIZE-1:0]                     bus_value
);

    typedef enum logic [0:0] {IDLE, HOLD} state_t;

    state_t                          state, state_n;
    logic [STATION_COUNT-1:0]        reserved, reserved_n;
    logic [LOCAL_INDEX_SIZE-1:0]     rr_pointer, rr_pointer_n;
    logic                            bus_request_n;
    logic [STATION_INDEX_SIZE-1:0]   bus_source_n;
    logic [SIZE-1:0]                 bus_value_n;
    logic [STATION_COUNT-1:0]        reset_occupied_n;

    logic [STATION_COUNT-1:0]        free;
    logic [STATION_COUNT-1:0]        candidates;
    logic                            any_candidate;
    logic [LOCAL_INDEX_SIZE-1:0]     sel;
    logic                            capture;
    logic                            found_free;

    assign free       = ~reserved;
    assign candidates = station_result_ready & reserved & ~reset_occupied;

    // Lowest-index free station
    always_comb begin
        dispatch_station = '0;
        found_free       = 1'b0;
        for (int unsigned i = 0; i < STATION_COUNT; i++) begin
            if (!found_free && free[LOCAL_INDEX_SIZE'(i)]) begin
                found_free       = 1'b1;
                dispatch_station = LOCAL_INDEX_SIZE'(i);
            end
        end
    end

    assign dispatch_ready = found_free && !flush;
    assign set_occupied   = (dispatch_valid && dispatch_ready)
                          ? (STATION_COUNT'(1) << dispatch_station) : '0;

    // First candidate at or above rr_pointer, wrapping
    always_comb begin
        sel           = '0;
        any_candidate = 1'b0;
        for (int unsigned i = 0; i < STATION_COUNT; i++) begin
            logic [LOCAL_INDEX_SIZE-1:0] idx;
            idx = LOCAL_INDEX_SIZE'((32'(rr_pointer) + i) % STATION_COUNT);
            if (!any_candidate && candidates[idx]) begin
                any_candidate = 1'b1;
                sel           = idx;
            end
        end
    end

    always_comb begin
        state_n          = state;
        reserved_n       = (reserved & ~reset_occupied) | set_occupied;
        rr_pointer_n     = rr_pointer;
        bus_request_n    = bus_request;
        bus_source_n     = bus_source;
        bus_value_n      = bus_value;
        reset_occupied_n = '0;
        capture          = 1'b0;

        if (flush) begin
            reserved_n       = '0;
            bus_request_n    = 1'b0;
            state_n          = IDLE;
            reset_occupied_n = '1;
        end else begin
            case (state)
                IDLE: capture = any_candidate;
                HOLD: begin
                    if (bus_grant) begin
`ifdef MUL_SCHED_BYPASS_EN
                        if (any_candidate) begin
                            capture = 1'b1;
                        end else begin
                            bus_request_n = 1'b0;
                            state_n       = IDLE;
                        end
`else
                        bus_request_n = 1'b0;
                        state_n       = IDLE;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (capture) begin
            bus_value_n      = station_result[sel];
            bus_source_n     = STATION_INDEX_SIZE'(STATION_BASE + 32'(sel));
            bus_request_n    = 1'b1;
            reset_occupied_n = STATION_COUNT'(1) << sel;
            rr_pointer_n     = LOCAL_INDEX_SIZE'((32'(sel) + 1) % STATION_COUNT);
            state_n          = HOLD;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            reserved       <= '0;
            rr_pointer     <= '0;
            bus_request    <= 1'b0;
            bus_source     <= '0;
            bus_value      <= '0;
            reset_occupied <= '0;
        end else begin
            state          <= state_n;
            reserved       <= reserved_n;
            rr_pointer     <= rr_pointer_n;
            bus_request    <= bus_request_n;
            bus_source     <= bus_source_n;
            bus_value      <= bus_value_n;
            reset_occupied <= reset_occupied_n;
        end
    end

endmodule
